mem_access_unit: RTL

Parametrised, multi-cycle successor to the pipeline MEM stage. It sits between EX/MEM and MEM/WB and drives an asynchronous SRAM through active-low control strobes. It supports byte, halfword and word loads and stores, with sign or zero extension and configurable wait states. The pipeline is stalled while an access is in flight; results return to write-back registered, with a valid strobe.

---
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multi-cycle load/store unit driving an async SRAM
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       reg2_i,
  output logic              stall_req_o,
  output logic              wb_valid_o,
  output logic [REG_AW-1:0] waddr_o,
  output logic              we_o,
  output logic [31:0]       wdata_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            state, state_d;
  logic [3:0]        cnt;
  logic [3:0]        op_q;
  logic [1:0]        a_q;
  logic [3:0]        be_q;
  logic [REG_AW-1:0] waddr_q;
  logic              we_q;

  logic        is_mem, is_byte, is_half, accept, trap, load_q, store_q;
  logic [1:0]  a_eff;
  logic [3:0]  be_d;
  logic [31:0] st_data, lane, ld_data;

  assign is_byte = (op_i == OP_LB) || (op_i == OP_LBU) || (op_i == OP_SB);
  assign is_half = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
  assign is_mem  = (op_i >= OP_LB) && (op_i <= OP_SW);
  assign accept  = valid_i && (state != S_ACCESS);
  assign load_q  = (op_q >= OP_LB) && (op_q <= OP_LW);
  assign store_q = (op_q >= OP_SB) && (op_q <= OP_SW);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem && ((is_half && mem_addr_i[0]) ||
                           ((op_i == OP_LW || op_i == OP_SW) && mem_addr_i[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Low address bits the access size cannot use are masked off
  always_comb begin
    a_eff   = 2'b00;
    be_d    = 4'b0000;
    st_data = reg2_i;
    if (is_byte) begin
      a_eff   = mem_addr_i[1:0];
      be_d    = ~(4'b0001 << mem_addr_i[1:0]);
      st_data = {4{reg2_i[7:0]}};
    end else if (is_half) begin
      a_eff   = {mem_addr_i[1], 1'b0};
      be_d    = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      st_data = {2{reg2_i[15:0]}};
    end
  end

  always_comb begin
    lane = sram_data_i >> {a_q, 3'b000};
    case (op_q)
      OP_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  ld_data = {24'd0, lane[7:0]};
      OP_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  ld_data = {16'd0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d     = state;
    stall_req_o = 1'b0;
    sram_ce_n_o = 1'b1;
    sram_oe_n_o = 1'b1;
    sram_we_n_o = 1'b1;
    sram_be_n_o = 4'b1111;
    case (state)
      S_ACCESS: begin
        stall_req_o = 1'b1;
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = ~load_q;
        sram_we_n_o = ~store_q;
        sram_be_n_o = be_q;
        if (cnt == 4'd0) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        if (accept && is_mem) begin
          stall_req_o = 1'b1;
          state_d     = trap ? S_DONE : S_ACCESS;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0; op_q <= 4'd0; a_q <= 2'd0; be_q <= 4'b1111;
      waddr_q <= '0; we_q <= 1'b0;
      sram_addr_o <= '0; sram_data_o <= 32'd0;
      wb_valid_o <= 1'b0; waddr_o <= '0; we_o <= 1'b0; wdata_o <= 32'd0;
      misalign_o <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      we_o       <= 1'b0;
      misalign_o <= 1'b0;
      if (state == S_ACCESS) begin
        if (cnt == 4'd0) begin
          wb_valid_o <= 1'b1;
          waddr_o    <= waddr_q;
          we_o       <= load_q && we_q;
          wdata_o    <= load_q ? ld_data : 32'd0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end else if (accept && !is_mem) begin
        wb_valid_o <= 1'b1;
        waddr_o    <= waddr_i;
        we_o       <= we_i;
        wdata_o    <= wdata_i;
      end else if (accept && trap) begin
        // Faulting address reported instead of data; no register write
        wb_valid_o <= 1'b1;
        waddr_o    <= waddr_i;
        wdata_o    <= 32'(mem_addr_i);
        misalign_o <= 1'b1;
      end else if (accept) begin
        cnt         <= WAIT_INIT;
        op_q        <= op_i;
        a_q         <= a_eff;
        be_q        <= be_d;
        waddr_q     <= waddr_i;
        we_q        <= we_i;
        sram_addr_o <= {mem_addr_i[ADDR_W-1:2], 2'b00};
        sram_data_o <= st_data;
      end
    end
  end

endmodule
